// File: rtl/mcu_sequencer.sv
// Fetch/execute sequencer for the 16-bit MCU: owns PC, SP and the hardware stack,
// with a req/ack fetch handshake, single-level interrupt entry and sticky stack faults.
module mcu_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [11:0] IRQ_VEC  = 12'hF00,
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [3:0]  ctrl,
  input  logic [11:0] branch_addr,
  input  logic        carry_in,
  input  logic        zero_in,
  input  logic [15:0] push_data,
  output logic [15:0] pop_data,
  output logic        pop_valid,
  output logic [11:0] pc,
  output logic [4:0]  sp,
  input  logic        irq,
  output logic        irq_ack,
  output logic        halted,
  output logic        fault
);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0]  SP_FULL = 6'(DEPTH);

  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_JC   = 4'd2;
  localparam logic [3:0] OP_JZ   = 4'd3;
  localparam logic [3:0] OP_CALL = 4'd4;
  localparam logic [3:0] OP_RET  = 4'd5;
  localparam logic [3:0] OP_PUSH = 4'd6;
  localparam logic [3:0] OP_POP  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_IRQ, S_HALT, S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [5:0]  sp_q, sp_d;
  logic        in_isr_q, in_isr_d;
  logic        run_low_q, run_low_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] pop_data_q, pop_data_d;
  logic        pop_valid_q, pop_valid_d;
  logic        irq_ack_q, irq_ack_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [15:0] stack_mem [DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;
  logic [15:0] top_word, push_word;
  logic [11:0] pc_inc;
  logic        push_en, go_fetch, stack_fault, st_full, st_empty;

  assign wr_idx   = sp_q[AW-1:0];
  assign rd_idx   = AW'(sp_q - 6'd1);
  assign top_word = stack_mem[rd_idx];
  assign pc_inc   = pc_q + 12'd1;
  assign st_full  = (sp_q >= SP_FULL);
  assign st_empty = (sp_q == 6'd0);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    in_isr_d    = in_isr_q;
    run_low_d   = run_low_q;
    mem_req_d   = 1'b0;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    irq_ack_d   = 1'b0;
    fault_d     = fault_q;
    push_en     = 1'b0;
    push_word   = 16'h0000;
    go_fetch    = 1'b0;
    stack_fault = 1'b0;

    case (state_q)
      S_IDLE: go_fetch = run;
      S_FETCH: begin
        if (mem_ack) state_d = S_EXEC;
        else         mem_req_d = 1'b1;
      end
      S_EXEC: begin
        go_fetch = 1'b1;
        pc_d     = pc_inc;
        case (ctrl)
          OP_JMP: pc_d = branch_addr;
          OP_JC:  if (carry_in) pc_d = branch_addr;
          OP_JZ:  if (zero_in)  pc_d = branch_addr;
          OP_CALL: begin
            if (st_full) stack_fault = 1'b1;
            else begin
              push_en   = 1'b1;
              push_word = {4'b0000, pc_inc};
              sp_d      = sp_q + 6'd1;
              pc_d      = branch_addr;
            end
          end
          OP_RET: begin
            if (st_empty) stack_fault = 1'b1;
            else begin
              sp_d        = sp_q - 6'd1;
              pc_d        = top_word[11:0];
              in_isr_d    = 1'b0;
              pop_data_d  = top_word;
              pop_valid_d = 1'b1;
            end
          end
          OP_PUSH: begin
            if (st_full) stack_fault = 1'b1;
            else begin
              push_en   = 1'b1;
              push_word = push_data;
              sp_d      = sp_q + 6'd1;
            end
          end
          OP_POP: begin
            if (st_empty) stack_fault = 1'b1;
            else begin
              sp_d        = sp_q - 6'd1;
              pop_data_d  = top_word;
              pop_valid_d = 1'b1;
            end
          end
          OP_HALT: begin
            go_fetch  = 1'b0;
            pc_d      = pc_q;
            run_low_d = 1'b0;
            state_d   = S_HALT;
          end
          default: ;
        endcase
        if (stack_fault) begin
          go_fetch = 1'b0;
          pc_d     = pc_q;
          fault_d  = 1'b1;
          state_d  = S_FAULT;
        end
      end
      S_IRQ: begin
        push_en   = 1'b1;
        push_word = {4'b0000, pc_q};
        sp_d      = sp_q + 6'd1;
        pc_d      = IRQ_VEC;
        in_isr_d  = 1'b1;
        go_fetch  = 1'b1;
      end
      S_HALT: begin
        // Both exits continue past the HALT; an interrupt returns there too.
        if (irq && !in_isr_q && !st_full) begin
          pc_d     = pc_inc;
          go_fetch = 1'b1;
        end else if (!run) begin
          run_low_d = 1'b1;
        end else if (run_low_q) begin
          pc_d     = pc_inc;
          go_fetch = 1'b1;
        end
      end
      default: ;
    endcase

    // Interrupt is taken on the way into FETCH, judged on the updated stack/ISR state.
    if (go_fetch) begin
      if (irq && !in_isr_d && (sp_d < SP_FULL)) begin
        state_d   = S_IRQ;
        irq_ack_d = 1'b1;
      end else begin
        state_d   = S_FETCH;
        mem_req_d = 1'b1;
      end
    end
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      sp_q        <= 6'd0;
      in_isr_q    <= 1'b0;
      run_low_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      pop_data_q  <= 16'h0000;
      pop_valid_q <= 1'b0;
      irq_ack_q   <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      in_isr_q    <= in_isr_d;
      run_low_q   <= run_low_d;
      mem_req_q   <= mem_req_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      irq_ack_q   <= irq_ack_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) stack_mem[wr_idx] <= push_word;
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign sp        = sp_q[4:0];
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign irq_ack   = irq_ack_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_mcu_sequencer.sv
// Bench for mcu_sequencer: directed vector table, hand-built corner sequences and a
// randomized run checked against an instruction-level model of the sequencer.
module tb_mcu_sequencer;
  localparam int          DEPTH    = 16;
  localparam logic [11:0] IRQ_VEC  = 12'hF00;
  localparam logic [11:0] RESET_PC = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [3:0]  ctrl = 4'd0;
  logic [11:0] branch_addr = 12'h000;
  logic        carry_in = 1'b0;
  logic        zero_in = 1'b0;
  logic [15:0] push_data = 16'h0000;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic [11:0] pc;
  logic [4:0]  sp;
  logic        irq = 1'b0;
  logic        irq_ack;
  logic        halted;
  logic        fault;

  mcu_sequencer #(.DEPTH(DEPTH), .IRQ_VEC(IRQ_VEC), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .ctrl(ctrl), .branch_addr(branch_addr), .carry_in(carry_in),
    .zero_in(zero_in), .push_data(push_data), .pop_data(pop_data), .pop_valid(pop_valid),
    .pc(pc), .sp(sp), .irq(irq), .irq_ack(irq_ack), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Instruction-level model: architectural state only.
  logic [11:0] m_pc;
  logic [15:0] m_stk[$];
  logic [15:0] m_pd;
  bit m_isr, m_fault, m_halt, m_pv, m_irq, m_idle;

  typedef struct {
    logic [3:0]  c;
    logic [11:0] br;
    logic        cy;
    logic        z;
    logic [15:0] pd;
    logic [11:0] addr;
    logic [11:0] npc;
    int          nsp;
    logic        pv;
    logic [15:0] pdo;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void model_reset();
    m_pc = RESET_PC;
    m_stk.delete();
    m_pd = 16'h0000;
    m_isr = 0; m_fault = 0; m_halt = 0; m_pv = 0; m_irq = 0; m_idle = 1;
  endfunction

  function automatic void model_exec(input logic [3:0] c, input logic [11:0] br,
                                     input logic cy, input logic z,
                                     input logic [15:0] pd, input logic iq);
    logic [11:0] nxt;
    nxt = m_pc + 12'd1;
    m_pv = 0;
    m_irq = 0;
    case (c)
      4'd1: m_pc = br;
      4'd2: m_pc = cy ? br : nxt;
      4'd3: m_pc = z ? br : nxt;
      4'd4: if (m_stk.size() == DEPTH) m_fault = 1;
            else begin m_stk.push_back({4'h0, nxt}); m_pc = br; end
      4'd5: if (m_stk.size() == 0) m_fault = 1;
            else begin m_pd = m_stk.pop_back(); m_pc = m_pd[11:0]; m_isr = 0; m_pv = 1; end
      4'd6: if (m_stk.size() == DEPTH) m_fault = 1;
            else begin m_stk.push_back(pd); m_pc = nxt; end
      4'd7: if (m_stk.size() == 0) m_fault = 1;
            else begin m_pd = m_stk.pop_back(); m_pv = 1; m_pc = nxt; end
      4'd8: m_halt = 1;
      default: m_pc = nxt;
    endcase
    if (!m_fault && !m_halt && iq && !m_isr && m_stk.size() < DEPTH) m_irq = 1;
  endfunction

  function automatic void model_irq_enter();
    m_stk.push_back({4'h0, m_pc});
    m_pc  = IRQ_VEC;
    m_isr = 1;
    m_pv  = 0;
    m_irq = 0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".sp"}, sp, m_stk.size());
    chk({tag, ".fault"}, fault, m_fault);
    chk({tag, ".halted"}, halted, m_halt);
    chk({tag, ".pop_valid"}, pop_valid, m_pv);
    chk({tag, ".pop_data"}, pop_data, m_pd);
    chk({tag, ".irq_ack"}, irq_ack, m_irq);
    chk({tag, ".mem_req"}, mem_req, !(m_idle || m_fault || m_halt || m_irq));
  endtask

  task automatic do_reset();
    rst = 1; run = 0; mem_ack = 0; ctrl = 0; branch_addr = 0;
    carry_in = 0; zero_in = 0; push_data = 0; irq = 0;
    tick(); tick();
    model_reset();
    check_outputs("reset");
    rst = 0;
  endtask

  task automatic start();
    run = 1;
    tick();
    m_idle = 0;
    check_outputs("start");
  endtask

  // One instruction: wait-state handshake, EXEC with the given operands, result check.
  task automatic exec_one(input logic [3:0] c, input logic [11:0] br, input logic cy,
                          input logic z, input logic [15:0] pd, input logic iq, input int lat);
    chk("fetch.req", mem_req, 1'b1);
    chk("fetch.addr", mem_addr, m_pc);
    mem_ack = 0;
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("fetch.req_hold", mem_req, 1'b1);
    end
    mem_ack = 1;
    tick();
    chk("exec.req_drop", mem_req, 1'b0);
    mem_ack = 0; ctrl = c; branch_addr = br; carry_in = cy; zero_in = z;
    push_data = pd; irq = iq;
    model_exec(c, br, cy, z, pd, iq);
    tick();
    irq = 0;
    check_outputs("post_exec");
    if (m_irq) begin
      model_irq_enter();
      tick();
      check_outputs("post_irq");
    end
  endtask

  task automatic halt_resume();
    run = 1; tick(); check_outputs("halt_hold");
    run = 0; tick(); check_outputs("halt_low");
    run = 1; tick();
    m_halt = 0;
    m_pc = m_pc + 12'd1;
    check_outputs("halt_resume");
  endtask

  task automatic fault_hold(input string tag);
    run = 0; tick();
    run = 1; tick(); tick();
    check_outputs(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc0;
    logic [3:0] rc;
    tbl[0]  = '{4'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 12'h000, 12'h001, 0, 1'b0, 16'h0000};
    tbl[1]  = '{4'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 12'h001, 12'h002, 0, 1'b0, 16'h0000};
    tbl[2]  = '{4'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 12'h002, 12'h003, 0, 1'b0, 16'h0000};
    tbl[3]  = '{4'd1, 12'h005, 1'b0, 1'b0, 16'h0000, 12'h003, 12'h005, 0, 1'b0, 16'h0000};
    tbl[4]  = '{4'd2, 12'h777, 1'b0, 1'b1, 16'h0000, 12'h005, 12'h006, 0, 1'b0, 16'h0000};
    tbl[5]  = '{4'd2, 12'h0FF, 1'b1, 1'b0, 16'h0000, 12'h006, 12'h0FF, 0, 1'b0, 16'h0000};
    tbl[6]  = '{4'd3, 12'h123, 1'b0, 1'b1, 16'h0000, 12'h0FF, 12'h123, 0, 1'b0, 16'h0000};
    tbl[7]  = '{4'd3, 12'h456, 1'b1, 1'b0, 16'h0000, 12'h123, 12'h124, 0, 1'b0, 16'h0000};
    tbl[8]  = '{4'd1, 12'hFFF, 1'b0, 1'b0, 16'h0000, 12'h124, 12'hFFF, 0, 1'b0, 16'h0000};
    tbl[9]  = '{4'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 12'hFFF, 12'h000, 0, 1'b0, 16'h0000};
    tbl[10] = '{4'd1, 12'h010, 1'b0, 1'b0, 16'h0000, 12'h000, 12'h010, 0, 1'b0, 16'h0000};
    tbl[11] = '{4'd4, 12'h200, 1'b0, 1'b0, 16'h0000, 12'h010, 12'h200, 1, 1'b0, 16'h0000};
    tbl[12] = '{4'd5, 12'h000, 1'b0, 1'b0, 16'h0000, 12'h200, 12'h011, 0, 1'b1, 16'h0011};
    tbl[13] = '{4'd6, 12'h000, 1'b0, 1'b0, 16'hBEEF, 12'h011, 12'h012, 1, 1'b0, 16'h0011};
    tbl[14] = '{4'd7, 12'h000, 1'b0, 1'b0, 16'h0000, 12'h012, 12'h013, 0, 1'b1, 16'hBEEF};
    tbl[15] = '{4'd9, 12'h0AA, 1'b1, 1'b1, 16'h0000, 12'h013, 12'h014, 0, 1'b0, 16'hBEEF};
    tbl[16] = '{4'd15, 12'h0BB, 1'b1, 1'b1, 16'h1234, 12'h014, 12'h015, 0, 1'b0, 16'hBEEF};

    // Reset values, then the directed table.
    do_reset();
    chk("reset.mem_addr", mem_addr, RESET_PC);
    start();
    cyc0 = cyc;
    for (int i = 0; i < 17; i++) begin
      if (i == 3) chk("nop_cycles", cyc - cyc0, 12);
      chk("tbl.addr", mem_addr, tbl[i].addr);
      exec_one(tbl[i].c, tbl[i].br, tbl[i].cy, tbl[i].z, tbl[i].pd, 1'b0, (i < 3) ? 2 : (i % 4));
      chk("tbl.pc", pc, tbl[i].npc);
      chk("tbl.sp", sp, tbl[i].nsp);
      chk("tbl.pop_valid", pop_valid, tbl[i].pv);
      chk("tbl.pop_data", pop_data, tbl[i].pdo);
    end

    // Overflow: DEPTH+1 pushes.
    do_reset(); start();
    for (int i = 0; i <= DEPTH; i++) exec_one(4'd6, 12'h000, 1'b0, 1'b0, 16'hA000 + 16'(i), 1'b0, 1);
    chk("ovf.fault", fault, 1'b1);
    chk("ovf.sp", sp, DEPTH);
    fault_hold("ovf_hold");

    // Underflow: POP on empty stack.
    do_reset(); start();
    exec_one(4'd7, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 0);
    chk("udf.fault", fault, 1'b1);
    fault_hold("udf_hold");

    // Interrupt during EXEC at 0x040, masked second irq, RET back to 0x041.
    do_reset(); start();
    exec_one(4'd1, 12'h040, 1'b0, 1'b0, 16'h0000, 1'b0, 2);
    exec_one(4'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b1, 2);
    chk("irq.pc", pc, IRQ_VEC);
    chk("irq.sp", sp, 1);
    exec_one(4'd0, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b1, 1);
    chk("irq.masked_pc", pc, IRQ_VEC + 12'd1);
    exec_one(4'd5, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
    chk("irq.ret_pc", pc, 12'h041);
    chk("irq.stack_top", pop_data, 16'h0041);

    // HALT: run low/high resume, then interrupt exit from HALT.
    exec_one(4'd8, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
    chk("halt.pc", pc, 12'h041);
    halt_resume();
    chk("halt.resume_pc", pc, 12'h042);
    exec_one(4'd8, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 0);
    irq = 1; tick(); irq = 0;
    m_halt = 0; m_pc = m_pc + 12'd1; m_irq = 1;
    check_outputs("halt_irq");
    model_irq_enter();
    tick();
    check_outputs("halt_isr");
    exec_one(4'd5, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
    chk("halt_irq.ret_pc", pc, 12'h043);

    // Reset while a fetch waits for ack.
    do_reset(); start();
    exec_one(4'd6, 12'h000, 1'b0, 1'b0, 16'h1234, 1'b0, 1);
    exec_one(4'd1, 12'h0AB, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
    mem_ack = 0;
    tick();
    chk("midfetch.req_before", mem_req, 1'b1);
    rst = 1;
    #1;
    chk("midfetch.req", mem_req, 1'b0);
    chk("midfetch.pc", pc, RESET_PC);
    chk("midfetch.sp", sp, 0);
    chk("midfetch.fault", fault, 1'b0);
    tick();

    // Randomized programs against the model.
    for (int seg = 0; seg < 25; seg++) begin
      do_reset(); start();
      for (int k = 0; k < 40; k++) begin
        rc = 4'($urandom_range(0, 15));
        exec_one(rc, 12'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        if (m_fault) begin
          fault_hold("rnd_fault_hold");
          break;
        end
        if (m_halt) halt_resume();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
